filter_quantizer: RTL
=====================

# filter_quantizer

Downstream stage of `filter5x5`: takes the 16-bit filter response (`Dout` qualified by `fill_now`), rounds and saturates it to an 8-bit pixel, tags line and frame boundaries, and buffers results in a small show-ahead FIFO. Consumers (display writer, next RWM) drain it through a valid/ready handshake. The filter has no backpressure input, so this block absorbs rate mismatch and flags any loss.

## Interface
- `IN_W`, 16: input data width.
- `SHIFT`, 8: right-shift applied after rounding, 1..IN_W-1.
- `IMG_W`, 320: pixels per line.
- `IMG_H`, 240: lines per frame.
- `FIFO_DEPTH`, 16: output FIFO entries, power of two.

- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `enable`  in  1: when 0, `in_valid` is ignored and the pixel counters hold.
- `clear`  in  1: synchronous clear of the sticky `overflow` flag only.
- `in_valid`  in  1: input pixel strobe, connected to `fill_now`.
- `in_data`  in  IN_W: unsigned filter response, connected to `Dout`.
- `out_ready`  in  1: consumer accepts the head entry this cycle.
- `out_valid`  out  1: FIFO not empty.
- `out_data`  out  8: head pixel.
- `out_eol`  out  1: head pixel is the last pixel of a line.
- `out_eof`  out  1: head pixel is the last pixel of the frame.
- `frame_done`  out  1: one-cycle pulse after the frame's last pixel has left the FIFO.
- `overflow`  out  1: sticky; a pixel was dropped because the FIFO was full.

## Operation
- **Quantize:** compute `sum = in_data + 2^(SHIFT-1)` in IN_W+1 bits, then `q = sum >> SHIFT`. If `q > 255`, output 255; otherwise output `q[7:0]`. The result is registered (stage 1).
- **Accept rule:** an input is accepted when `enable && in_valid` and the FSM is in IDLE or RUN.
- **Counters:** `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1, both advancing on each accepted input. `eol = (col == IMG_W-1)` and `eof = eol && (row == IMG_H-1)`. Both are registered with the quantized pixel. `col` wraps to 0 at `eol` and `row` increments. Both counters reset to 0 at `eof`.
- **FIFO:** each entry is 10 bits {eof, eol, pixel}. The FIFO is written on the cycle after stage 1 loads, and is show-ahead: the head is visible whenever `out_valid = 1`.
  - Pop occurs when `out_valid && out_ready`.
  - A write while full with a pop in the same cycle is accepted, and count is unchanged.
  - A write while full without a pop drops the pixel and sets `overflow`. Counters still advance, so framing stays aligned.
  - `out_ready` while empty has no effect.
- **FSM:**
  - IDLE: on the first accepted input, go to RUN.
  - RUN: on an accepted input with `eof`, go to DRAIN.
  - DRAIN: inputs are ignored (not counted, not written). When the FIFO is empty and stage 1 is empty, go to DONE.
  - DONE: assert `frame_done` for 1 cycle, then go to IDLE.
- **overflow:** set on a dropped write. Cleared only by reset or by `clear`. If a set and a `clear` occur in the same cycle, set wins.

## Timing
- **Reset values:** `out_valid = 0`, `out_data = 0`, `out_eol = 0`, `out_eof = 0`, `frame_done = 0`, `overflow = 0`. FSM in IDLE, counters 0, FIFO empty, stage 1 invalid.
- **Latency:** input sampled at edge t; stage 1 loads at t; the FIFO is written at edge t+1. With the FIFO empty, `out_valid` and head data are visible after edge t+1, i.e. a 2-clock input-to-output latency.
- **Throughput:** one pixel per clock in; one pixel per clock out while `out_ready = 1`.
- **End of frame:** `frame_done` rises the cycle after the pop of the `eof` entry. Assuming no input and `out_ready` held at 1, this is edge t+3 relative to the sampled `eof` input. Next-frame pixels arriving before `frame_done` are lost. The upstream controller is required to sequence frames.
- **Reset mid-operation:** `rst_n = 0` at any edge restores all reset values next cycle. Buffered FIFO contents are discarded.
- **enable = 0** mid-line: counters hold; stage 1 and the FIFO keep draining.

## Test plan
- **Reset:** assert `rst_n = 0` for 2 clocks with `in_valid = 1` -> all outputs 0, `out_valid = 0` throughout.
- **Quantization** (SHIFT=8, `out_ready = 1`), each input mapping to its output:
  - 0x0000 -> 0
  - 0x007F -> 0
  - 0x0080 -> 1
  - 0x7F80 -> 0x80
  - 0xFF7F -> 255
  - 0xFFFF -> 255 (saturated)
  - Each output appears 2 clocks after its input.
- **Framing** (IMG_W=4, IMG_H=2): 8 consecutive pixels ->
  - `out_eol` on pixels 4 and 8.
  - `out_eof` on pixel 8 only.
  - `frame_done` a single pulse one cycle after pixel 8 pops.
  - A 9th input sent during DRAIN never appears.
- **Overflow** (FIFO_DEPTH=16, `out_ready = 0`): 17 pixels ->
  - 16 stored, pixel 17 dropped, `overflow = 1`.
  - Draining yields exactly the first 16 in order.
  - Pulsing `clear` returns `overflow` to 0.
- **Full with simultaneous pop:** FIFO full, `out_ready = 1` and a new write in the same cycle -> no drop, `overflow` stays 0, count stays 16.
- **Reset mid-frame:** after 3 pixels with 2 buffered, pulse `rst_n` low -> FIFO empty, counters 0. The next 8 pixels frame correctly, with `out_eol` on pixel 4.

Source files
------------

// File: rtl/filter_quantizer_if.sv
// Pixel stream between filter5x5 and its consumers: unacknowledged input strobe in,
// show-ahead valid/ready output carrying the 8-bit pixel with line/frame tags.
interface filter_quantizer_if #(
  parameter int IN_W = 16
);
  logic            in_valid;
  logic [IN_W-1:0] in_data;
  logic            out_ready;
  logic            out_valid;
  logic [7:0]      out_data;
  logic            out_eol;
  logic            out_eof;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_eol, out_eof
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_eol, out_eof
  );
endinterface

// File: rtl/filter_quantizer.sv
// Rounds/saturates the filter response to 8 bits, tags eol/eof, buffers in a show-ahead FIFO; 2-clock latency.
// No input backpressure: a write into a full FIFO without a same-cycle pop is dropped and flagged sticky.
module fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          wr_en;
  logic          rd_en;

  assign rd_vld = (cnt != '0);
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign rd_en  = rd_vld && rd_rdy;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign wr_en  = wr_vld && (!full || rd_en);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_dat;
  end
endmodule

module filter_quantizer #(
  parameter int IN_W       = 16,
  parameter int SHIFT      = 8,
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  filter_quantizer_if.slave    bus,
  output logic                 frame_done,
  output logic                 overflow
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [IN_W:0] RND = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic [IN_W:0] sum;
  logic [IN_W:0] q;
  logic [7:0]    pix_q;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          eol_in;
  logic          eof_in;
  logic          s1_vld;
  logic [7:0]    s1_pix;
  logic          s1_eol;
  logic          s1_eof;
  logic          fifo_vld;
  logic          fifo_full;
  logic [9:0]    head;
  logic          drop;

  assign accept = enable && bus.in_valid && ((state == IDLE) || (state == RUN));

  // Extra MSB keeps the rounding carry so full-scale inputs saturate instead of wrapping.
  assign sum   = {1'b0, bus.in_data} + RND;
  assign q     = sum >> SHIFT;
  assign pix_q = (q > (IN_W+1)'(255)) ? 8'hFF : q[7:0];

  assign eol_in = (col == CW'(IMG_W - 1));
  assign eof_in = eol_in && (row == RW'(IMG_H - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (eof_in) begin
        col <= '0;
        row <= '0;
      end else if (eol_in) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_pix <= '0;
      s1_eol <= 1'b0;
      s1_eof <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_pix <= pix_q;
        s1_eol <= eol_in;
        s1_eof <= eof_in;
      end
    end
  end

  fifo #(
    .W     (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (s1_vld),
    .wr_dat ({s1_eof, s1_eol, s1_pix}),
    .rd_rdy (bus.out_ready),
    .rd_vld (fifo_vld),
    .rd_dat (head),
    .full   (fifo_full)
  );

  assign drop = s1_vld && fifo_full && !(fifo_vld && bus.out_ready);

  // Set has priority over clear so a drop in the clearing cycle is never lost.
  always_ff @(posedge clk) begin
    if (!rst_n)     overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
    else if (clear) overflow <= 1'b0;
  end

  assign bus.out_valid = fifo_vld;
  assign bus.out_data  = fifo_vld ? head[7:0] : 8'h00;
  assign bus.out_eol   = fifo_vld && head[8];
  assign bus.out_eof   = fifo_vld && head[9];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = eof_in ? DRAIN : RUN;
      RUN:   if (accept && eof_in) state_nxt = DRAIN;
      DRAIN: if (!fifo_vld && !s1_vld) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
